alu_pipe: RTL and testbench

- Parametrised, 2-stage pipelined ALU; successor to the fixed 4-bit registered ALU.
- Adds WIDTH generalisation, XOR/ADC/shift ops, a negative flag and a valid/ready handshake with full backpressure.
- Sits between the operand sequencer and the result capture/side-channel monitor.
- Throughput of 1 op/cycle when the output is not stalled.

---
 rtl/alu_pipe.sv | 169 ++++++++++++++++
 tb/tb_alu_pipe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: 2-stage pipelined ALU with a valid/ready handshake and full backpressure.
// Define ALU_PIPE_ACT_CNT_EN to add the result toggle-activity counter (clr_act / act_cnt).
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int ACT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             overflow,
    output logic             negative
`ifdef ALU_PIPE_ACT_CNT_EN
    ,
    input  logic             clr_act,
    output logic [ACT_W-1:0] act_cnt
`endif
);

    localparam int SH_W = $clog2(WIDTH);
    localparam int MSB  = WIDTH - 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_ADC = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic             s1_cin;
    logic             s2_valid;
    logic             adv1;
    logic             adv2;

    logic [WIDTH:0]   ext_a;
    logic [WIDTH:0]   ext_b;
    logic [WIDTH:0]   calc;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;
    logic [SH_W-1:0]  sh;
    logic [WIDTH-1:0] nxt_result;
    logic             nxt_carry;
    logic             nxt_ovf;

    assign adv2      = !s2_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
            s1_cin   <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a   <= a;
                s1_b   <= b;
                s1_op  <= op;
                s1_cin <= cin;
            end
        end
    end

    // Everything is computed one bit wider so carry/borrow falls out of bit WIDTH;
    // SHR shifts a copy padded with a low zero so the last bit shifted out lands in bit 0.
    always_comb begin
        ext_a     = {1'b0, s1_a};
        ext_b     = {1'b0, s1_b};
        sh        = s1_b[SH_W-1:0];
        shl_ext   = ext_a << sh;
        shr_ext   = {s1_a, 1'b0} >> sh;
        calc      = '0;
        nxt_carry = 1'b0;
        nxt_ovf   = 1'b0;
        case (op_e'(s1_op))
            OP_ADD, OP_ADC: begin
                calc      = ext_a + ext_b + {{WIDTH{1'b0}}, (s1_op == OP_ADC) && s1_cin};
                nxt_carry = calc[WIDTH];
                nxt_ovf   = (s1_a[MSB] == s1_b[MSB]) && (calc[MSB] != s1_a[MSB]);
            end
            OP_SUB: begin
                calc      = ext_a - ext_b;
                nxt_carry = calc[WIDTH];
                nxt_ovf   = (s1_a[MSB] != s1_b[MSB]) && (calc[MSB] != s1_a[MSB]);
            end
            OP_AND: calc = {1'b0, s1_a & s1_b};
            OP_OR:  calc = {1'b0, s1_a | s1_b};
            OP_XOR: calc = {1'b0, s1_a ^ s1_b};
            OP_SHL: begin
                calc      = shl_ext;
                nxt_carry = shl_ext[WIDTH];
            end
            OP_SHR: begin
                calc      = {1'b0, shr_ext[WIDTH:1]};
                nxt_carry = shr_ext[0];
            end
            default: calc = '0;
        endcase
        nxt_result = calc[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            result   <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            negative <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result   <= nxt_result;
                carry    <= nxt_carry;
                zero     <= (nxt_result == '0);
                overflow <= nxt_ovf;
                negative <= nxt_result[MSB];
            end
        end
    end

`ifdef ALU_PIPE_ACT_CNT_EN
    localparam int POP_W = $clog2(WIDTH + 1);

    logic [POP_W-1:0] toggles;
    logic [ACT_W:0]   act_sum;

    // Toggle count between the result about to be loaded and the one currently held.
    always_comb begin
        toggles = '0;
        for (int i = 0; i < WIDTH; i++) begin
            toggles = toggles + POP_W'(nxt_result[i] ^ result[i]);
        end
        act_sum = {1'b0, act_cnt} + (ACT_W + 1)'(toggles);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_cnt <= '0;
        end else if (clr_act) begin
            act_cnt <= '0;
        end else if (adv2 && s1_valid) begin
            act_cnt <= act_sum[ACT_W] ? '1 : act_sum[ACT_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed scoreboard bench for alu_pipe; a negedge monitor pops expected beats.
module tb_alu_pipe;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
    localparam logic [2:0] XOR_ = 3'b100, ADC = 3'b101, SHL = 3'b110, SHR = 3'b111;

    typedef struct packed {
        logic [7:0] result;
        logic       carry;
        logic       zero;
        logic       overflow;
        logic       negative;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] op = '0;
    logic       cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] result;
    logic       carry, zero, overflow, negative;
`ifdef ALU_PIPE_ACT_CNT_EN
    logic        clr_act = 1'b0;
    logic [15:0] act_cnt;
`endif

    int    tests_run = 0;
    int    failures = 0;
    int    beat_idx = 0;
    int    consec = 0;
    int    max_consec = 0;
    bit    prev_pop = 0;
    bit    held = 0;
    beat_t held_beat;
    beat_t cur;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(8), .ACT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .zero(zero),
        .overflow(overflow), .negative(negative)
`ifdef ALU_PIPE_ACT_CNT_EN
        , .clr_act(clr_act), .act_cnt(act_cnt)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic beat_t mk(input logic [7:0] r, input logic c, z, v, n);
        return {r, c, z, v, n};
    endfunction

    // Monitor: scoreboard pops on every accepted result and checks stability while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            held     = 0;
            prev_pop = 0;
        end else begin
            cur = {result, carry, zero, overflow, negative};
            if (out_valid && !out_ready) begin
                if (held) checkOutput("stall_hold", 32'(cur), 32'(held_beat));
                held      = 1;
                held_beat = cur;
            end else begin
                held = 0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) checkOutput("unexpected_beat", 32'(cur), 32'hFFFF_FFFF);
                else checkOutput($sformatf("beat%0d", beat_idx), 32'(cur), 32'(exp_q.pop_front()));
                beat_idx++;
                consec     = prev_pop ? consec + 1 : 1;
                max_consec = (consec > max_consec) ? consec : max_consec;
                prev_pop   = 1;
            end else begin
                prev_pop = 0;
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] o, input logic [7:0] va, input logic [7:0] vb,
                                 input logic vc, input beat_t expv);
        bit done = 0;
        op = o; a = va; b = vb; cin = vc; in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        if (done) exp_q.push_back(expv);
        else checkOutput("in_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_outputs", 32'({result, carry, zero, overflow, negative}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(ADD,  8'hFF, 8'h01, 1'b0, mk(8'h00, 1, 1, 0, 0));
        applyStimulus(SUB,  8'h80, 8'h01, 1'b0, mk(8'h7F, 0, 0, 1, 0));
        applyStimulus(SUB,  8'h01, 8'h02, 1'b0, mk(8'hFF, 1, 0, 0, 1));
        applyStimulus(SHL,  8'h81, 8'h03, 1'b0, mk(8'h08, 0, 0, 0, 0));
        applyStimulus(SHR,  8'h81, 8'h01, 1'b0, mk(8'h40, 1, 0, 0, 0));
        applyStimulus(SHL,  8'h5A, 8'h00, 1'b0, mk(8'h5A, 0, 0, 0, 0));
        applyStimulus(SHR,  8'hA5, 8'h08, 1'b0, mk(8'hA5, 0, 0, 0, 1));
        applyStimulus(AND_, 8'hF0, 8'h3C, 1'b1, mk(8'h30, 0, 0, 0, 0));
        applyStimulus(OR_,  8'hF0, 8'h0F, 1'b0, mk(8'hFF, 0, 0, 0, 1));
        applyStimulus(XOR_, 8'hAA, 8'hAA, 1'b0, mk(8'h00, 0, 1, 0, 0));
        applyStimulus(ADD,  8'h70, 8'h10, 1'b1, mk(8'h80, 0, 0, 1, 1));
        drain();

        // ADC burst: a=i*16, b=0x0F, cin=1 gives (i+1)*16; the last one overflows into the sign bit.
        max_consec = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(ADC, 8'(i * 16), 8'h0F, 1'b1,
                          mk(8'((i + 1) * 16), 0, 0, i == 7, i == 7));
        end
        drain();
        checkOutput("burst_consecutive", 32'(max_consec), 32'd8);

        out_ready = 1'b0;
        applyStimulus(ADD,  8'h01, 8'h02, 1'b0, mk(8'h03, 0, 0, 0, 0));
        applyStimulus(XOR_, 8'h0F, 8'hF0, 1'b0, mk(8'hFF, 0, 0, 0, 1));
        in_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        out_ready = 1'b0;
        applyStimulus(ADD, 8'hFF, 8'h01, 1'b0, mk(8'h00, 1, 1, 0, 0));
        applyStimulus(OR_, 8'h80, 8'h00, 1'b0, mk(8'h80, 0, 0, 0, 1));
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_outputs", 32'({result, carry, zero, overflow, negative}), 32'd0);
        checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("post_flush_in_ready", 32'(in_ready), 32'd1);
        checkOutput("post_flush_out_valid", 32'(out_valid), 32'd0);

`ifdef ALU_PIPE_ACT_CNT_EN
        applyStimulus(ADD,  8'h00, 8'h00, 1'b0, mk(8'h00, 0, 1, 0, 0));
        applyStimulus(OR_,  8'hFF, 8'h00, 1'b0, mk(8'hFF, 0, 0, 0, 1));
        drain();
        checkOutput("act_cnt_8", 32'(act_cnt), 32'd8);
        applyStimulus(AND_, 8'h0F, 8'hFF, 1'b0, mk(8'h0F, 0, 0, 0, 0));
        drain();
        checkOutput("act_cnt_12", 32'(act_cnt), 32'd12);
        clr_act = 1'b1;
        applyStimulus(XOR_, 8'h0F, 8'h0F, 1'b0, mk(8'h00, 0, 1, 0, 0));
        drain();
        clr_act = 1'b0;
        checkOutput("act_cnt_clr", 32'(act_cnt), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
